dmem_responder: RTL

- Data-memory target for the RISC-V core's load/store path. The core's datapath issues the requests; this block is the responding end.
- Accepts one word-granular request at a time over a valid/ready handshake.
- Applies a parameterised wait-state delay, performs a byte-enabled write or a word read, then returns the result over a second valid/ready channel.
- Replaces the zero-latency data memory so the core and its memory interface can be exercised against realistic latency and back-pressure.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 46 ++++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and FSM encoding for the data-memory responder.
// Imported by the bus interface, the storage array and the responder.
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int STRB_W     = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request and response valid/ready channels
// between the core's load/store path (master) and the memory (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 10
);
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_wstrb,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_wstrb,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: word-addressed storage with byte-enable write and
// registered read; contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-3:0] idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
        rdata <= '0;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-memory target with WAIT_CYCLES latency.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned requests with rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  dmem_responder_if.slave bus
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  state_t state;
  state_t nxt;

  logic [WAIT_CNT_W-1:0] cnt;
  logic                  wr_q;
  logic [ADDR_W-3:0]     idx_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  err_q;

  logic                  accept;
  logic                  arr_en;
  logic [WORD_W-1:0]     arr_rdata;

  assign accept = (state == IDLE) && bus.req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_ONE) begin
          nxt = ACCESS;
        end
      end
      ACCESS: begin
        nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Request fields are captured at accept so later req_* changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= WAIT_INIT;
      wr_q    <= bus.req_write;
      idx_q   <= bus.req_addr[ADDR_W-1:2];
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
      err_q   <= ALIGN_CHECK && (bus.req_addr[1:0] != 2'b00);
    end else if (state == WAIT) begin
      cnt     <= cnt - CNT_ONE;
    end
  end

  // Array strobe is purely state-decoded, so reset before the
  // ACCESS closing edge leaves the word untouched.
  assign arr_en = (state == ACCESS) && !err_q;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (wr_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.rsp_rdata = ((state == RESP) && !err_q) ? arr_rdata : '0;

endmodule
